mdio_controller: RTL

Station-management (master) side of the MDIO link. It accepts a 32-bit management frame from the host, generates MDC from the system clock, and serializes the frame MSB-first on MDIO_OUT. For reads it releases the line at turnaround, captures 16 bits returned by the PHY-side receptor, and reports them on RD_DATA. It sits directly upstream of the MDIO receptor: its MDC/MDIO_OUT/MDIO_OE drive the receptor, and the receptor's returned data arrives on MDIO_IN.

---
 rtl/mdio_controller_if.sv | 37 +++
 rtl/mdio_controller.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/mdio_controller_if.sv
// Host/PHY-facing signal bundle of the MDIO station-management controller.
// The slave modport is the controller itself; master is the host plus the PHY return path.
interface mdio_controller_if;
    logic        mdio_start_i;
    logic [31:0] t_data_i;
    logic        mdio_in_i;
    logic        mdc_o;
    logic        mdio_out_o;
    logic        mdio_oe_o;
    logic [15:0] rd_data_o;
    logic        mdio_done_o;
    logic        busy_o;

    modport slave (
        input  mdio_start_i,
        input  t_data_i,
        input  mdio_in_i,
        output mdc_o,
        output mdio_out_o,
        output mdio_oe_o,
        output rd_data_o,
        output mdio_done_o,
        output busy_o
    );

    modport master (
        output mdio_start_i,
        output t_data_i,
        output mdio_in_i,
        input  mdc_o,
        input  mdio_out_o,
        input  mdio_oe_o,
        input  rd_data_o,
        input  mdio_done_o,
        input  busy_o
    );
endinterface

// File: rtl/mdio_controller.sv
// MDIO station-management master: serializes a 32-bit frame on MDC/MDIO, captures 16-bit read data.
// Optional 32-bit all-ones preamble is compiled in with `define MDIO_PREAMBLE_EN.
module mdio_controller #(
    parameter int unsigned DIV = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    mdio_controller_if.slave bus
);

    localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

`ifdef MDIO_PREAMBLE_EN
    typedef enum logic [1:0] {S_IDLE, S_PRE, S_FRAME, S_DONE} state_t;
    localparam state_t S_FIRST = S_PRE;
`else
    typedef enum logic [1:0] {S_IDLE, S_FRAME, S_DONE} state_t;
    localparam state_t S_FIRST = S_FRAME;
`endif

    state_t        state_q, state_d;
    logic [31:0]   sh_q, sh_d;
    logic [15:0]   cap_q, cap_d;
    logic [15:0]   rd_q, rd_d;
    logic [DW-1:0] div_q, div_d;
    logic [5:0]    bit_q, bit_d;
    logic          mdc_q, mdc_d;
    logic          oe_q, oe_d;
    logic          is_rd_q, is_rd_d;
    logic          phase_end;

    assign phase_end = (div_q == DIV_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            cap_q   <= '0;
            rd_q    <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            mdc_q   <= 1'b0;
            oe_q    <= 1'b0;
            is_rd_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cap_q   <= cap_d;
            rd_q    <= rd_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            mdc_q   <= mdc_d;
            oe_q    <= oe_d;
            is_rd_q <= is_rd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cap_d   = cap_q;
        rd_d    = rd_q;
        div_d   = div_q;
        bit_d   = bit_q;
        mdc_d   = mdc_q;
        oe_d    = oe_q;
        is_rd_d = is_rd_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                mdc_d = 1'b0;
                oe_d  = 1'b0;
                div_d = '0;
                bit_d = '0;
                if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
                // DONE deasserts BUSY, so a request landing there is taken immediately
                if (bus.mdio_start_i) begin
                    sh_d    = bus.t_data_i;
                    is_rd_d = (bus.t_data_i[29:28] == 2'b10);
                    cap_d   = '0;
                    oe_d    = 1'b1;
                    state_d = S_FIRST;
                end
            end

`ifdef MDIO_PREAMBLE_EN
            S_PRE: begin
                if (phase_end) begin
                    div_d = '0;
                    if (!mdc_q) begin
                        mdc_d = 1'b1;
                    end else begin
                        mdc_d = 1'b0;
                        bit_d = bit_q + 6'd1;
                        if (bit_q == 6'd31) begin
                            bit_d   = '0;
                            state_d = S_FRAME;
                        end
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
`endif

            S_FRAME: begin
                if (phase_end) begin
                    div_d = '0;
                    if (!mdc_q) begin
                        // Rising MDC: sample the PHY during the 16 data bits of a read
                        mdc_d = 1'b1;
                        if (is_rd_q && (bit_q >= 6'd16)) begin
                            cap_d = {cap_q[14:0], bus.mdio_in_i};
                        end
                    end else begin
                        mdc_d = 1'b0;
                        sh_d  = {sh_q[30:0], 1'b0};
                        bit_d = bit_q + 6'd1;
                        // Reads release the line from bit 14 (first TA bit) onward
                        oe_d  = !(is_rd_q && (bit_q >= 6'd13));
                        if (bit_q == 6'd31) begin
                            state_d = S_DONE;
                            oe_d    = 1'b0;
                            bit_d   = '0;
                            if (is_rd_q) begin
                                rd_d = cap_q;
                            end
                        end
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef MDIO_PREAMBLE_EN
    assign bus.mdio_out_o = (state_q == S_PRE) ? 1'b1 : sh_q[31];
`else
    assign bus.mdio_out_o = sh_q[31];
`endif
    assign bus.mdc_o       = mdc_q;
    assign bus.mdio_oe_o   = oe_q;
    assign bus.rd_data_o   = rd_q;
    assign bus.mdio_done_o = (state_q == S_DONE);
    assign bus.busy_o      = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule
